iq_sample_buffer: RTL and testbench
===================================

Name: iq_sample_buffer

Overview:
- Sits directly upstream of the Ethernet packetizer, in the same clk domain.
- Accepts a stream of 16-bit ADC/DDC samples, interleaved I then Q, and pairs them into 32-bit {I[15:0], Q[15:0]} words.
- Buffers the words in a synchronous FIFO and presents them on a first-word-fall-through read port (rd_en / rd_data / rd_dr).
- Reports overflow and underflow because the packetizer pops without checking rd_dr.

Parameters:
- ADDR_W, 10, FIFO address width; depth = 2**ADDR_W 32-bit words.
- SAMPLE_W, 16, width of one I or Q sample; rd_data width = 2*SAMPLE_W.

Ports:
- clk  in  1  system clock, same as the packetizer.
- rst  in  1  reset, synchronous, active-high.
- s_valid  in  1  sample strobe; one sample per cycle when high.
- s_data  in  16  sample value, two's complement.
- s_is_i  in  1  high = this sample is I; low = Q.
- rd_en  in  1  pop request from the packetizer; 1-cycle pulse.
- rd_data  out  32  head word {I,Q}; valid while rd_dr is high.
- rd_dr  out  1  data ready: FIFO not empty.
- level  out  ADDR_W+1  current occupancy, 0..2**ADDR_W.
- clear_flags  in  1  clears overflow, underflow and drop_count.
- overflow  out  1  sticky: an IQ word was dropped because the FIFO was full.
- underflow  out  1  sticky: rd_en was asserted while the FIFO was empty.
- drop_count  out  16  number of dropped IQ words; saturates at 16'hFFFF.

Behaviour:
- Reset: all outputs 0. This clears level, rd_dr, rd_data, flags, drop_count, pointers and the pairing state. FIFO contents are don't-care. Reset mid-operation discards buffered data and any half-pair.
- Pairing FSM has two states, WAIT_I and WAIT_Q; reset state is WAIT_I.
  - WAIT_I, s_valid & s_is_i: latch s_data as I, go to WAIT_Q.
  - WAIT_I, s_valid & ~s_is_i: discard the orphan Q, stay in WAIT_I. Not counted as a drop.
  - WAIT_Q, s_valid & ~s_is_i: form {I, s_data}, issue a push, go to WAIT_I.
  - WAIT_Q, s_valid & s_is_i: replace the latched I with the new sample (resync), stay in WAIT_Q.
- Push:
  - If the FIFO is not full, or a pop occurs in the same cycle, write the word at the edge ending the Q cycle.
  - Otherwise drop it: set overflow and increment drop_count, saturating.
- Pop: valid only when rd_dr=1. The head advances at the edge ending the rd_en cycle. The consumer samples rd_data in the same cycle it asserts rd_en.
- rd_en with rd_dr=0: no pointer change; set underflow. rd_data reads 32'h0 whenever the FIFO is empty.
- rd_data is a combinational read of the head entry (register or distributed memory).
- Latency: a word pushed at edge N gives rd_dr=1 and valid rd_data in cycle N+1.
- Simultaneous push and pop:
  - Non-empty, non-full: level unchanged.
  - Full: both succeed, no overflow.
  - Empty: the pop is ignored and flagged as underflow; the push succeeds, so level becomes 1.
- Pointers are ADDR_W bits and wrap modulo the depth. level is kept as its own ADDR_W+1 bit counter; full = (level == 2**ADDR_W).
- clear_flags in the same cycle as a new overflow or underflow event: the event wins, so the flag stays set and drop_count = 1.

Optional Feature:
- Macro: IQ_TEST_PATTERN_EN.
- When defined, adds input test_mode (1 bit). While test_mode=1, s_data and s_is_i are ignored and each s_valid pushes the word {cnt[15:0], ~cnt[15:0]}. cnt is a 16-bit wrapping counter, reset to 0, that increments per push attempt, including dropped ones.
- When not defined, there is no test_mode port and no counter logic.

Decomposition:
- Package sdr_pkg holds:
  - IQ_W = 32 and SAMPLE_W = 16 constants.
  - The iq_word_t typedef {i, q}.
  - The pairing-state enum (WAIT_I, WAIT_Q).
- Sub-module iq_fifo_core: generic synchronous FWFT FIFO (ADDR_W, DATA_W), with push/pop/full/empty/level.
- iq_sample_buffer keeps the pairing FSM, flags, drop counter and test pattern.

Test Plan:
- Reset, then I=16'h1234, Q=16'hABCD on consecutive cycles → next cycle rd_dr=1, rd_data=32'h1234ABCD, level=1. A rd_en pulse → rd_dr=0, rd_data=0.
- Sequence Q(5), I(1), I(2), Q(3) → exactly one word, 32'h00020003; no drop, no overflow.
- ADDR_W=3: push 9 pairs with no pops → level=8, overflow=1, drop_count=1. The first 8 words pop out in order.
- At full, push and rd_en in the same cycle → level stays 8, overflow stays 0, and the new word ends up last.
- rd_en while empty → underflow=1, level=0. Then clear_flags → underflow=0.
- Push and pop 2**ADDR_W+3 words continuously → data integrity across pointer wrap; drop_count saturation at 16'hFFFF checked with a forced-full long run.

Source files
------------

// File: rtl/sdr_pkg.sv
// Shared constants and types for the IQ sample path.
package sdr_pkg;

    localparam int SAMPLE_W = 16;
    localparam int IQ_W     = 32;

    // One paired IQ word as it sits in the buffer: I in the upper half.
    typedef struct packed {
        logic [SAMPLE_W-1:0] i;
        logic [SAMPLE_W-1:0] q;
    } iq_word_t;

    // Pairing state: which half of the next word we are waiting for.
    typedef enum logic {
        WAIT_I = 1'b0,
        WAIT_Q = 1'b1
    } pair_state_t;

endpackage

// File: rtl/iq_fifo_core.sv
// Generic synchronous first-word-fall-through FIFO.
// rd_data is a combinational read of the head entry and reads zero while empty.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module iq_fifo_core #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              push_ok
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level_q;
    logic              pop_ok;

    assign empty   = (level_q == '0);
    assign full    = (level_q == (ADDR_W + 1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign level   = level_q;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage write; contents are not reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/iq_sample_buffer.sv
// Pairs interleaved I/Q samples into {I,Q} words and buffers them in a FWFT FIFO
// for the packetizer. Overflow/underflow are sticky because the packetizer pops
// blindly. Optional build macro IQ_TEST_PATTERN_EN adds a test_mode input that
// replaces the sample stream with a {cnt, ~cnt} counter pattern.
//
// state  | meaning
// WAIT_I | no I latched; an arriving Q is an orphan and is discarded
// WAIT_Q | I latched; next Q completes a word, a new I replaces the latched one
module iq_sample_buffer
    import sdr_pkg::pair_state_t, sdr_pkg::WAIT_I, sdr_pkg::WAIT_Q, sdr_pkg::iq_word_t;
#(
    parameter int ADDR_W   = 10,
    parameter int SAMPLE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [SAMPLE_W-1:0]   s_data,
    input  logic                  s_is_i,
`ifdef IQ_TEST_PATTERN_EN
    input  logic                  test_mode,
`endif
    input  logic                  rd_en,
    output logic [2*SAMPLE_W-1:0] rd_data,
    output logic                  rd_dr,
    output logic [ADDR_W:0]       level,
    input  logic                  clear_flags,
    output logic                  overflow,
    output logic                  underflow,
    output logic [15:0]           drop_count
);

    pair_state_t           state_q;
    pair_state_t           state_d;
    logic [SAMPLE_W-1:0]   i_q;
    logic                  latch_i;
    logic                  push_req;
    logic [2*SAMPLE_W-1:0] push_word;
    logic                  push_ok;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  drop_evt;
    logic                  under_evt;
    logic                  overflow_q;
    logic                  underflow_q;
    logic [15:0]           drop_count_q;

`ifdef IQ_TEST_PATTERN_EN
    logic [15:0] tp_cnt;
    iq_word_t    tp_word;

    assign tp_word.i = tp_cnt;
    assign tp_word.q = ~tp_cnt;

    // Pattern counter advances on every push attempt in test mode, dropped or not.
    always_ff @(posedge clk) begin
        if (rst) begin
            tp_cnt <= '0;
        end else if (test_mode && s_valid) begin
            tp_cnt <= tp_cnt + 1'b1;
        end
    end
`endif

    // Pairing state register and latched I half.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_I;
            i_q     <= '0;
        end else begin
            state_q <= state_d;
            if (latch_i) begin
                i_q <= s_data;
            end
        end
    end

    // Pairing next-state and push request; test mode bypasses pairing entirely.
    always_comb begin
        state_d   = state_q;
        latch_i   = 1'b0;
        push_req  = 1'b0;
        push_word = {i_q, s_data};
`ifdef IQ_TEST_PATTERN_EN
        if (test_mode) begin
            push_req  = s_valid;
            push_word = (2 * SAMPLE_W)'(tp_word);
        end else if (s_valid) begin
`else
        if (s_valid) begin
`endif
            case (state_q)
                WAIT_I: begin
                    if (s_is_i) begin
                        latch_i = 1'b1;
                        state_d = WAIT_Q;
                    end
                end
                WAIT_Q: begin
                    if (s_is_i) begin
                        latch_i = 1'b1;
                    end else begin
                        push_req = 1'b1;
                        state_d  = WAIT_I;
                    end
                end
                default: state_d = WAIT_I;
            endcase
        end
    end

    iq_fifo_core #(
        .ADDR_W (ADDR_W),
        .DATA_W (2 * SAMPLE_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (push_word),
        .pop       (rd_en),
        .rd_data   (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level),
        .push_ok   (push_ok)
    );

    assign rd_dr     = ~fifo_empty;
    assign drop_evt  = push_req & ~push_ok;
    assign under_evt = rd_en & fifo_empty;

    // Sticky flags and saturating drop counter; a new event beats clear_flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            drop_count_q <= '0;
        end else begin
            if (drop_evt) begin
                overflow_q <= 1'b1;
            end else if (clear_flags) begin
                overflow_q <= 1'b0;
            end

            if (under_evt) begin
                underflow_q <= 1'b1;
            end else if (clear_flags) begin
                underflow_q <= 1'b0;
            end

            if (drop_evt) begin
                if (clear_flags) begin
                    drop_count_q <= 16'd1;
                end else if (drop_count_q != 16'hFFFF) begin
                    drop_count_q <= drop_count_q + 1'b1;
                end
            end else if (clear_flags) begin
                drop_count_q <= '0;
            end
        end
    end

    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign drop_count = drop_count_q;

    // Documents that the package word type matches the rd_data layout.
    if ($bits(iq_word_t) != 2 * SAMPLE_W && SAMPLE_W == 16) begin : g_bad_width
        $error("iq_word_t width does not match 2*SAMPLE_W");
    end

endmodule

// File: tb/tb_iq_sample_buffer.sv
// Directed bench for iq_sample_buffer with an 8-deep FIFO.
module tb_iq_sample_buffer;

    localparam int ADDR_W = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_is_i = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic        rd_dr;
    logic [ADDR_W:0] level;
    logic        clear_flags = 1'b0;
    logic        overflow;
    logic        underflow;
    logic [15:0] drop_count;
`ifdef IQ_TEST_PATTERN_EN
    logic        test_mode = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    iq_sample_buffer #(.ADDR_W(ADDR_W), .SAMPLE_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_is_i      (s_is_i),
`ifdef IQ_TEST_PATTERN_EN
        .test_mode   (test_mode),
`endif
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_dr       (rd_dr),
        .level       (level),
        .clear_flags (clear_flags),
        .overflow    (overflow),
        .underflow   (underflow),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one I cycle then one Q cycle; rd_en optionally asserted in the Q cycle.
    task automatic push_pair(input logic [15:0] i_val, input logic [15:0] q_val, input logic pop_q);
        s_valid = 1'b1; s_is_i = 1'b1; s_data = i_val;
        step();
        s_is_i = 1'b0; s_data = q_val; rd_en = pop_q;
        step();
        s_valid = 1'b0; rd_en = 1'b0;
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    function automatic logic [31:0] w3(input int k);
        return {16'h1000 + 16'(k), 16'h2000 + 16'(k)};
    endfunction

    function automatic logic [31:0] w6(input int k);
        return {16'h3000 + 16'(k), 16'h4000 + 16'(k)};
    endfunction

    initial begin
        // reset
        step(); step();
        rst = 1'b0;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_rd_dr", 32'(rd_dr), 32'd0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);

        // basic pair and pop
        push_pair(16'h1234, 16'hABCD, 1'b0);
        chk("pair_rd_dr", 32'(rd_dr), 32'd1);
        chk("pair_rd_data", rd_data, 32'h1234ABCD);
        chk("pair_level", 32'(level), 32'd1);
        rd_en = 1'b1;
        chk("pair_data_at_pop", rd_data, 32'h1234ABCD);
        step();
        rd_en = 1'b0;
        chk("pop_rd_dr", 32'(rd_dr), 32'd0);
        chk("pop_rd_data", rd_data, 32'h0);
        chk("pop_underflow", 32'(underflow), 32'd0);

        // orphan Q and I resync: Q(5) I(1) I(2) Q(3)
        s_valid = 1'b1; s_is_i = 1'b0; s_data = 16'd5; step();
        s_is_i = 1'b1; s_data = 16'd1; step();
        s_data = 16'd2; step();
        s_is_i = 1'b0; s_data = 16'd3; step();
        s_valid = 1'b0;
        chk("sync_level", 32'(level), 32'd1);
        chk("sync_word", rd_data, 32'h00020003);
        chk("sync_overflow", 32'(overflow), 32'd0);
        chk("sync_drop", 32'(drop_count), 32'd0);
        pop_one();

        // fill past full
        for (int k = 0; k < 9; k++) push_pair(16'h1000 + 16'(k), 16'h2000 + 16'(k), 1'b0);
        chk("full_level", 32'(level), 32'd8);
        chk("full_overflow", 32'(overflow), 32'd1);
        chk("full_drop", 32'(drop_count), 32'd1);
        clear_flags = 1'b1; step(); clear_flags = 1'b0;
        chk("clr_overflow", 32'(overflow), 32'd0);
        chk("clr_drop", 32'(drop_count), 32'd0);

        // push with pop at full
        chk("fullpop_head", rd_data, w3(0));
        push_pair(16'hAAAA, 16'h5555, 1'b1);
        chk("fullpop_level", 32'(level), 32'd8);
        chk("fullpop_overflow", 32'(overflow), 32'd0);
        chk("fullpop_drop", 32'(drop_count), 32'd0);
        for (int k = 1; k < 8; k++) begin
            chk($sformatf("drain_%0d", k), rd_data, w3(k));
            pop_one();
        end
        chk("drain_last", rd_data, 32'hAAAA5555);
        pop_one();
        chk("drain_level", 32'(level), 32'd0);
        chk("drain_underflow", 32'(underflow), 32'd0);

        // underflow and clear
        pop_one();
        chk("uf_flag", 32'(underflow), 32'd1);
        chk("uf_level", 32'(level), 32'd0);
        clear_flags = 1'b1; step(); clear_flags = 1'b0;
        chk("uf_clear", 32'(underflow), 32'd0);
        rd_en = 1'b1; clear_flags = 1'b1; step(); rd_en = 1'b0; clear_flags = 1'b0;
        chk("uf_beats_clear", 32'(underflow), 32'd1);
        clear_flags = 1'b1; step(); clear_flags = 1'b0;

        // push and pop on empty
        push_pair(16'h0F0F, 16'hF0F0, 1'b1);
        chk("emptypp_level", 32'(level), 32'd1);
        chk("emptypp_underflow", 32'(underflow), 32'd1);
        chk("emptypp_word", rd_data, 32'h0F0FF0F0);
        pop_one();
        clear_flags = 1'b1; step(); clear_flags = 1'b0;

        // continuous stream across pointer wrap
        for (int n = 0; n < 11; n++) begin
            s_valid = 1'b1; s_is_i = 1'b1; s_data = 16'h3000 + 16'(n);
            if (n > 0) begin
                rd_en = 1'b1;
                chk($sformatf("wrap_%0d", n - 1), rd_data, w6(n - 1));
            end
            step();
            rd_en = 1'b0; s_is_i = 1'b0; s_data = 16'h4000 + 16'(n);
            step();
            s_valid = 1'b0;
        end
        chk("wrap_10", rd_data, w6(10));
        chk("wrap_level", 32'(level), 32'd1);
        pop_one();
        chk("wrap_end_level", 32'(level), 32'd0);
        chk("wrap_overflow", 32'(overflow), 32'd0);
        chk("wrap_underflow", 32'(underflow), 32'd0);

        // drop counter saturation from a preloaded count
        for (int k = 0; k < 8; k++) push_pair(16'h5000 + 16'(k), 16'h6000 + 16'(k), 1'b0);
        chk("sat_fill_level", 32'(level), 32'd8);
        force dut.drop_count_q = 16'hFFFD;
        #1;
        release dut.drop_count_q;
        push_pair(16'h7000, 16'h7001, 1'b0);
        chk("sat_fffe", 32'(drop_count), 32'h0000FFFE);
        chk("sat_overflow", 32'(overflow), 32'd1);
        push_pair(16'h7002, 16'h7003, 1'b0);
        chk("sat_ffff", 32'(drop_count), 32'h0000FFFF);
        push_pair(16'h7004, 16'h7005, 1'b0);
        chk("sat_hold", 32'(drop_count), 32'h0000FFFF);
        chk("sat_level", 32'(level), 32'd8);

        // drop in the same cycle as clear_flags
        s_valid = 1'b1; s_is_i = 1'b1; s_data = 16'h7100; step();
        s_is_i = 1'b0; s_data = 16'h7101; clear_flags = 1'b1; step();
        s_valid = 1'b0; clear_flags = 1'b0;
        chk("clrdrop_count", 32'(drop_count), 32'd1);
        chk("clrdrop_overflow", 32'(overflow), 32'd1);
        chk("clrdrop_head", rd_data, 32'h50006000);

        // reset mid-operation
        s_valid = 1'b1; s_is_i = 1'b1; s_data = 16'h7777; step();
        s_valid = 1'b0; rst = 1'b1; step(); rst = 1'b0;
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_drop", 32'(drop_count), 32'd0);
        s_valid = 1'b1; s_is_i = 1'b0; s_data = 16'h0001; step();
        s_valid = 1'b0;
        chk("midrst_halfpair", 32'(level), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
